// File: rtl/conv_pe_param.sv
// Convolution PE: signed MAC, NUM_RES-slot quantised buffer, MEM_DEPTH-word result RAM, valid/ready drain.
// Optional PE_SAT_EN: saturating quantisation with a sticky ovf_flag; undefined = wrap, ovf_flag tied 0.
module conv_pe_param #(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 24,
    parameter int OUT_W     = 8,
    parameter int SHIFT     = 0,
    parameter int NUM_RES   = 4,
    parameter int MEM_DEPTH = 128
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          acc_clr,
    input  logic                          acc_en,
    input  logic signed [DATA_W-1:0]      pixel,
    input  logic signed [DATA_W-1:0]      weight,
    input  logic                          res_clr,
    input  logic                          res_en,
    input  logic [$clog2(NUM_RES)-1:0]    res_index,
    input  logic                          wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0]  wr_adr,
    input  logic                          drain_start,
    output logic                          drain_busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_RES*OUT_W-1:0]      out_data,
    output logic [$clog2(MEM_DEPTH)-1:0]  out_adr,
    output logic                          ovf_flag
);
    localparam int IDX_W  = $clog2(NUM_RES);
    localparam int AW     = $clog2(MEM_DEPTH);
    localparam int WORD_W = NUM_RES * OUT_W;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_HOLD} state_t;

    state_t                     state_reg, state_next;
    logic signed [ACC_W-1:0]    acc_reg, acc_next;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic [OUT_W-1:0]           q;
    logic [WORD_W-1:0]          buf_word;
    logic [WORD_W-1:0]          mem [MEM_DEPTH];
    logic [WORD_W-1:0]          rd_data_reg;
    logic [AW-1:0]              rd_ptr_reg;
    logic [AW:0]                hwm_reg;
    logic [AW:0]                wr_end;
    logic                       wr_accept;
    logic                       last_word;

    assign prod     = pixel * weight;
    assign prod_ext = ACC_W'(prod);

    always_comb begin
        acc_next = acc_reg;
        if (acc_clr && acc_en)
            acc_next = prod_ext;
        else if (acc_clr)
            acc_next = '0;
        else if (acc_en)
            acc_next = acc_reg + prod_ext;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc_reg <= '0;
        else
            acc_reg <= acc_next;
    end

`ifdef PE_SAT_EN
    localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((1 << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] Q_MIN = ~Q_MAX;

    logic signed [ACC_W-1:0] shifted;
    logic                    q_clamp;
    logic                    ovf_reg;

    assign shifted = acc_reg >>> SHIFT;

    always_comb begin
        q       = shifted[OUT_W-1:0];
        q_clamp = 1'b0;
        if (shifted > Q_MAX) begin
            q       = {1'b0, {(OUT_W-1){1'b1}}};
            q_clamp = 1'b1;
        end else if (shifted < Q_MIN) begin
            q       = {1'b1, {(OUT_W-1){1'b0}}};
            q_clamp = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ovf_reg <= 1'b0;
        else if (res_clr)
            ovf_reg <= 1'b0;
        else if (res_en && q_clamp)
            ovf_reg <= 1'b1;
    end

    assign ovf_flag = ovf_reg;
`else
    assign q        = OUT_W'(acc_reg >>> SHIFT);
    assign ovf_flag = 1'b0;
`endif

    // One register per slot; the packed view is what gets written to memory.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RES; gi++) begin : g_slot
            logic [OUT_W-1:0] slot_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    slot_reg <= '0;
                else if (res_clr)
                    slot_reg <= '0;
                else if (res_en && res_index == IDX_W'(gi))
                    slot_reg <= q;
            end
            assign buf_word[gi*OUT_W +: OUT_W] = slot_reg;
        end
    endgenerate

    assign wr_accept = wr_en && (state_reg == S_IDLE);
    assign wr_end    = (AW+1)'(wr_adr) + (AW+1)'(1);
    assign last_word = ((AW+1)'(rd_ptr_reg) + (AW+1)'(1)) == hwm_reg;

    // Plain array with registered read so the memory maps onto block RAM; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[wr_adr] <= buf_word;
        if (state_reg == S_READ)
            rd_data_reg <= mem[rd_ptr_reg];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (drain_start && hwm_reg != '0) state_next = S_READ;
            S_READ:  state_next = S_HOLD;
            S_HOLD:  if (out_ready) state_next = last_word ? S_IDLE : S_READ;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            rd_ptr_reg <= '0;
            hwm_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE && drain_start)
                rd_ptr_reg <= '0;
            if (state_reg == S_HOLD && out_ready) begin
                if (last_word)
                    hwm_reg <= '0;
                else
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (wr_accept && wr_end > hwm_reg)
                hwm_reg <= wr_end;
        end
    end

    // Gate the data path so the outputs read zero whenever no word is on offer.
    assign drain_busy = (state_reg != S_IDLE);
    assign out_valid  = (state_reg == S_HOLD);
    assign out_data   = out_valid ? rd_data_reg : '0;
    assign out_adr    = out_valid ? rd_ptr_reg  : '0;

endmodule
